// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration frame loader: FSM states,
// register-map address codes and the frame checksum helper.
package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CSUM    = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_ACC    = 3'b000;
    localparam logic [2:0] ADDR_GYRO   = 3'b001;
    localparam logic [2:0] ADDR_MAG    = 3'b010;
    localparam logic [2:0] ADDR_DEC    = 3'b011;
    localparam logic [2:0] ADDR_DT     = 3'b100;
    localparam logic [2:0] ADDR_NOLOAD = 3'b111;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Running frame checksum: XOR of payload bytes only.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/cfg_timeout_counter.sv
// Idle-cycle watchdog: counts enabled cycles and flags the cycle in which the
// count would reach TIMEOUT_CYCLES; the counter then restarts from zero.
module cfg_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Expiry happens on the edge that would make the count equal TIMEOUT_CYCLES.
    assign o_expired = i_enable & ~i_clear & (r_count == LAST_CNT);

    // Idle-cycle counter with clear priority over increment.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear || o_expired) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/config_frame_loader.sv
// Buffers one SYNC/payload/checksum frame from the host link and, only if the
// checksum matches, writes the payload to the register map one entry per cycle.
module config_frame_loader
    import cfg_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         NUM_REGS       = 5,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [2:0] addr_out,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_error
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_cnt_inc;
    logic [7:0]       r_acc;
    logic [7:0]       r_buf [NUM_REGS];
    logic [2:0]       r_addr;
    logic [7:0]       r_data;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic w_accept;
    logic w_in_frame;
    logic w_expired;
    logic w_start;
    logic w_store;
    logic w_commit_start;
    logic w_commit_step;
    logic w_commit_end;
    logic w_error;

    assign rx_ready   = (r_state != COMMIT);
    assign w_accept   = rx_valid & rx_ready;
    assign w_in_frame = (r_state == PAYLOAD) || (r_state == CSUM);
    assign w_cnt_inc  = r_cnt + IDX_W'(1);

    assign addr_out  = r_addr;
    assign data_out  = r_data;
    assign busy      = r_busy;
    assign cfg_done  = r_done;
    assign cfg_error = r_err;

    cfg_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_clear   (~w_in_frame | w_accept),
        .i_enable  (w_in_frame & ~w_accept),
        .o_expired (w_expired)
    );

    // Next-state decode and datapath strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_start        = 1'b0;
        w_store        = 1'b0;
        w_commit_start = 1'b0;
        w_commit_step  = 1'b0;
        w_commit_end   = 1'b0;
        w_error        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = PAYLOAD;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PAYLOAD: begin
                if (w_expired) begin
                    w_state_nxt = IDLE;
                    w_error     = 1'b1;
                end else if (w_accept) begin
                    w_store = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = CSUM;
                    end else begin
                        w_state_nxt = PAYLOAD;
                    end
                end else begin
                    w_state_nxt = PAYLOAD;
                end
            end
            CSUM: begin
                if (w_expired) begin
                    w_state_nxt = IDLE;
                    w_error     = 1'b1;
                end else if (w_accept) begin
                    if (rx_data == r_acc) begin
                        w_state_nxt    = COMMIT;
                        w_commit_start = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_error     = 1'b1;
                    end
                end else begin
                    w_state_nxt = CSUM;
                end
            end
            COMMIT: begin
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt  = IDLE;
                    w_commit_end = 1'b1;
                end else begin
                    w_state_nxt   = COMMIT;
                    w_commit_step = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, frame buffer and registered register-map outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_acc   <= 8'h00;
            r_addr  <= ADDR_NOLOAD;
            r_data  <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_commit_end;
            r_err   <= w_error;

            if (w_start) begin
                r_idx <= '0;
                r_acc <= 8'h00;
            end else if (w_store) begin
                r_buf[r_idx] <= rx_data;
                r_acc        <= csum_update(r_acc, rx_data);
                r_idx        <= r_idx + IDX_W'(1);
            end else begin
                r_idx <= r_idx;
                r_acc <= r_acc;
            end

            // data_out keeps its last committed value once the address returns to no-load.
            if (w_commit_start) begin
                r_cnt  <= '0;
                r_addr <= ADDR_ACC;
                r_data <= r_buf[0];
            end else if (w_commit_step) begin
                r_cnt  <= w_cnt_inc;
                r_addr <= 3'(w_cnt_inc);
                r_data <= r_buf[w_cnt_inc];
            end else begin
                r_cnt  <= r_cnt;
                r_addr <= ADDR_NOLOAD;
                r_data <= r_data;
            end
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// Self-checking bench for config_frame_loader: expected register writes are
// queued when a frame is sent and compared whenever addr_out leaves no-load.
module tb_config_frame_loader;
    import cfg_pkg::*;

    localparam int         NUM_REGS = 5;
    localparam int         TIMEOUT  = 1000;
    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [39:0] F1 = {8'h50, 8'h40, 8'h30, 8'h20, 8'h10};
    localparam logic [39:0] F2 = {8'h05, 8'h04, 8'hA5, 8'h02, 8'h01};

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [2:0] addr_out;
    logic [7:0] data_out;
    logic       busy;
    logic       cfg_done;
    logic       cfg_error;

    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;
    int n_err = 0;
    logic [10:0] exp_q [$];

    config_frame_loader #(
        .SYNC_BYTE      (SYNC),
        .NUM_REGS       (NUM_REGS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every non-no-load address is a register write that must match the queue head.
    task automatic monitor();
        logic [10:0] e;
        if (cfg_done === 1'b1) n_done++;
        if (cfg_error === 1'b1) n_err++;
        if (addr_out !== ADDR_NOLOAD) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_write: got addr=%0d data=%02h, required no write", addr_out, data_out);
            end else begin
                e = exp_q.pop_front();
                if ({addr_out, data_out} !== e) begin
                    $display("FAIL sb_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             addr_out, data_out, e[10:8], e[7:0]);
                end else begin
                    n_pass++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        logic got;
        got = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !got; i++) begin
            acc = rx_ready;
            step();
            got = acc;
        end
        if (!got) begin
            n_total++;
            $display("FAIL send_accept: byte %02h not accepted, required acceptance within 50 cycles", b);
        end
    endtask

    task automatic send_body(input logic [39:0] p, input logic [7:0] cs);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            send_byte(p[8*k +: 8]);
            x = x ^ p[8*k +: 8];
        end
        if (cs == x) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                exp_q.push_back({3'(k), p[8*k +: 8]});
            end
        end
        send_byte(cs);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] p, input logic [7:0] cs);
        send_byte(SYNC);
        send_body(p, cs);
    endtask

    task automatic run_until_done(output int cyc);
        cyc = 0;
        while (cfg_done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #12;
        n_total++;
        if ({addr_out, data_out, busy, cfg_done, cfg_error, rx_ready} !== {ADDR_NOLOAD, 8'h00, 4'b0001}) begin
            $display("FAIL reset_values: got addr=%0d data=%02h busy=%b done=%b err=%b rdy=%b, required 7/00/0/0/0/1",
                     addr_out, data_out, busy, cfg_done, cfg_error, rx_ready);
        end else n_pass++;
        @(negedge clk);
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_valid_frame();
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        send_frame(F1, 8'h10);
        for (int k = 0; k < NUM_REGS; k++) begin
            n_total++;
            if (addr_out !== 3'(k)) begin
                $display("FAIL valid_commit_addr: got %0d, required %0d", addr_out, k);
            end else n_pass++;
            step();
        end
        n_total++;
        if (addr_out !== ADDR_NOLOAD || cfg_done !== 1'b1 || data_out !== 8'h50) begin
            $display("FAIL valid_done: got addr=%0d done=%b data=%02h, required 7/1/50", addr_out, cfg_done, data_out);
        end else n_pass++;
        step();
        n_total++;
        if (cfg_done !== 1'b0 || (n_done - d0) != 1 || n_err != e0) begin
            $display("FAIL valid_done_pulse: got done=%b pulses=%0d errs=%0d, required 0/1/0",
                     cfg_done, n_done - d0, n_err - e0);
        end else n_pass++;
    endtask

    task automatic test_bad_checksum();
        int e0;
        e0 = n_err;
        send_frame(F1, 8'h11);
        n_total++;
        if (cfg_error !== 1'b1 || addr_out !== ADDR_NOLOAD) begin
            $display("FAIL badcs_error: got err=%b addr=%0d, required 1/7", cfg_error, addr_out);
        end else n_pass++;
        step();
        n_total++;
        if (cfg_error !== 1'b0 || busy !== 1'b0 || (n_err - e0) != 1) begin
            $display("FAIL badcs_after: got err=%b busy=%b pulses=%0d, required 0/0/1", cfg_error, busy, n_err - e0);
        end else n_pass++;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_leading_garbage();
        logic [7:0] g [3];
        int cyc;
        g[0] = 8'h00; g[1] = 8'hFF; g[2] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (rx_ready !== 1'b1) begin
                $display("FAIL garbage_ready: got rx_ready=%b, required 1", rx_ready);
            end else n_pass++;
            send_byte(g[i]);
        end
        rx_valid = 1'b0;
        n_total++;
        if (busy !== 1'b0) begin
            $display("FAIL garbage_busy: got busy=%b, required 0", busy);
        end else n_pass++;
        send_frame(F1, 8'h10);
        run_until_done(cyc);
        n_total++;
        if (cyc != NUM_REGS) begin
            $display("FAIL garbage_commit_len: got %0d cycles, required %0d", cyc, NUM_REGS);
        end else n_pass++;
        step();
    endtask

    task automatic test_timeout();
        int n, cyc;
        send_byte(SYNC);
        send_byte(8'h10);
        rx_valid = 1'b0;
        n = 0;
        while (cfg_error !== 1'b1 && n < TIMEOUT + 50) begin
            step();
            n++;
        end
        n_total++;
        if (n != TIMEOUT || busy !== 1'b0) begin
            $display("FAIL timeout_cycles: got error after %0d idle cycles busy=%b, required %0d/0", n, busy, TIMEOUT);
        end else n_pass++;
        step();
        send_frame(F1, 8'h10);
        run_until_done(cyc);
        n_total++;
        if (cyc != NUM_REGS) begin
            $display("FAIL timeout_recover: got %0d cycles, required %0d", cyc, NUM_REGS);
        end else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        send_frame(F1, 8'h10);
        rx_valid = 1'b1;
        rx_data  = SYNC;
        for (int k = 0; k < NUM_REGS; k++) begin
            n_total++;
            if (rx_ready !== 1'b0) begin
                $display("FAIL bp_ready_low: got rx_ready=%b in commit cycle %0d, required 0", rx_ready, k);
            end else n_pass++;
            step();
        end
        n_total++;
        if (cfg_done !== 1'b1 || rx_ready !== 1'b1) begin
            $display("FAIL bp_release: got done=%b rdy=%b, required 1/1", cfg_done, rx_ready);
        end else n_pass++;
        step();
        n_total++;
        if (busy !== 1'b1) begin
            $display("FAIL bp_new_frame: got busy=%b, required 1", busy);
        end else n_pass++;
        send_body(F2, 8'hA7);
        run_until_done(cyc);
        n_total++;
        if (cyc != NUM_REGS) begin
            $display("FAIL bp_second_commit: got %0d cycles, required %0d", cyc, NUM_REGS);
        end else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_commit();
        int cyc;
        send_frame(F1, 8'h10);
        step();
        step();
        n_total++;
        if (addr_out !== ADDR_MAG) begin
            $display("FAIL rst_precond: got addr=%0d, required 2", addr_out);
        end else n_pass++;
        #2;
        n_rst = 1'b0;
        #1;
        n_total++;
        if (addr_out !== ADDR_NOLOAD || data_out !== 8'h00 || busy !== 1'b0 || rx_ready !== 1'b1) begin
            $display("FAIL rst_async: got addr=%0d data=%02h busy=%b rdy=%b, required 7/00/0/1",
                     addr_out, data_out, busy, rx_ready);
        end else n_pass++;
        exp_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        step();
        send_byte(8'h10);
        rx_valid = 1'b0;
        step();
        n_total++;
        if (busy !== 1'b0 || addr_out !== ADDR_NOLOAD) begin
            $display("FAIL rst_idle: got busy=%b addr=%0d, required 0/7", busy, addr_out);
        end else n_pass++;
        send_frame(F2, 8'hA7);
        run_until_done(cyc);
        n_total++;
        if (cyc != NUM_REGS) begin
            $display("FAIL rst_recover: got %0d cycles, required %0d", cyc, NUM_REGS);
        end else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_leading_garbage();
        test_timeout();
        test_back_to_back();
        test_reset_mid_commit();
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL sb_leftover: got %0d unconsumed writes, required 0", exp_q.size());
        end else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
